// File: rtl/smem_bwd_ctrl_stage.sv
// rtl/smem_bwd_ctrl_stage.sv - SMEM backward-extension control stage with 2-entry elastic output buffer
module smem_bwd_ctrl_stage #(
  parameter int IDX_W      = 7,
  parameter int READ_NUM_W = 6,
  parameter int PEND_W     = 256,
  parameter int TOK_W      = 96,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_status,
  input  logic [READ_NUM_W-1:0] in_read_num,
  input  logic [IDX_W-1:0]      in_rd_addr,
  input  logic [IDX_W-1:0]      in_wr_addr,
  input  logic [IDX_W-1:0]      in_mem_wr_addr,
  input  logic [IDX_W-1:0]      in_fwd_size,
  input  logic [IDX_W-1:0]      in_new_size,
  input  logic [IDX_W-1:0]      in_new_last_size,
  input  logic [IDX_W-1:0]      in_bwd_i,
  input  logic [IDX_W-1:0]      in_bwd_j,
  input  logic [7:0]            in_output_c,
  input  logic [IDX_W-1:0]      in_min_intv,
  input  logic                  in_iter_bound,
  input  logic [63:0]           in_primary,
  input  logic [PEND_W-1:0]     in_pend,
  input  logic [TOK_W-1:0]      in_tok,
  output logic [5:0]            out_status,
  output logic [READ_NUM_W-1:0] out_read_num,
  output logic [IDX_W-1:0]      out_rd_addr,
  output logic [IDX_W-1:0]      out_wr_addr,
  output logic [IDX_W-1:0]      out_mem_wr_addr,
  output logic [IDX_W-1:0]      out_fwd_size,
  output logic [IDX_W-1:0]      out_new_size,
  output logic [IDX_W-1:0]      out_new_last_size,
  output logic [IDX_W-1:0]      out_bwd_i,
  output logic [IDX_W-1:0]      out_bwd_j,
  output logic [7:0]            out_output_c,
  output logic [IDX_W-1:0]      out_min_intv,
  output logic                  out_iter_bound,
  output logic [63:0]           out_primary,
  output logic [PEND_W-1:0]     out_pend,
  output logic [TOK_W-1:0]      out_tok,
  output logic                  out_finish,
  output logic                  out_last_one,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      bck_step_cnt
);

  localparam logic [5:0] ST_BCK_INI = 6'b001000;
  localparam logic [5:0] ST_BCK_RUN = 6'b010000;

  typedef struct packed {
    logic [5:0]            status;
    logic [READ_NUM_W-1:0] read_num;
    logic [IDX_W-1:0]      rd_addr;
    logic [IDX_W-1:0]      wr_addr;
    logic [IDX_W-1:0]      mem_wr_addr;
    logic [IDX_W-1:0]      fwd_size;
    logic [IDX_W-1:0]      new_size;
    logic [IDX_W-1:0]      new_last_size;
    logic [IDX_W-1:0]      bwd_i;
    logic [IDX_W-1:0]      bwd_j;
    logic [7:0]            output_c;
    logic [IDX_W-1:0]      min_intv;
    logic                  iter_bound;
    logic [63:0]           primary;
    logic [PEND_W-1:0]     pend;
    logic [TOK_W-1:0]      tok;
    logic                  finish;
    logic                  last_one;
  } beat_t;

  beat_t       w_in;
  beat_t       w_proc;
  beat_t       w_head;
  beat_t       r_mem [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [1:0]  w_count_next;
  logic        r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic        w_push;
  logic        w_pop;
  logic        w_jb;
  logic        w_ib;
  logic        w_ibn;

  assign w_in = {in_status, in_read_num, in_rd_addr, in_wr_addr, in_mem_wr_addr,
                 in_fwd_size, in_new_size, in_new_last_size, in_bwd_i, in_bwd_j,
                 in_output_c, in_min_intv, in_iter_bound, in_primary, in_pend,
                 in_tok, 1'b0, 1'b0};

  // Zero-size guard keeps new_last_size-1 from wrapping into a false match.
  assign w_jb  = (in_new_last_size == '0) || (in_bwd_j == (in_new_last_size - IDX_W'(1)));
  assign w_ib  = w_jb && (in_bwd_i != '0);
  assign w_ibn = w_jb && (in_bwd_i == '0);

  always_comb begin
    w_proc = '0;
    case (in_status)
      ST_BCK_INI: begin
        w_proc          = w_in;
        w_proc.output_c = '0;
        w_proc.pend     = '0;
      end
      ST_BCK_RUN: begin
        w_proc               = w_in;
        w_proc.finish        = w_jb && (in_new_size == '0);
        w_proc.last_one      = w_jb && (in_new_size == IDX_W'(1));
        w_proc.iter_bound    = in_iter_bound | w_ibn;
        w_proc.bwd_i         = in_iter_bound ? '0 : (w_ib ? in_bwd_i - IDX_W'(1) : in_bwd_i);
        w_proc.bwd_j         = w_jb ? '0 : in_bwd_j + IDX_W'(1);
        w_proc.wr_addr       = w_jb ? in_fwd_size - IDX_W'(1) : in_wr_addr;
        w_proc.new_last_size = w_jb ? in_new_size : in_new_last_size;
        w_proc.new_size      = w_jb ? '0 : in_new_size;
      end
      default: w_proc = '0;
    endcase
  end

  assign w_push       = in_valid && r_in_ready;
  assign w_pop        = (r_count != 2'd0) && out_ready;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem      <= '{default: '0};
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_proc;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != 2'd2);
      if (w_push && (in_status == ST_BCK_RUN) && w_ib && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_head            = r_mem[r_rd_ptr];
  assign in_ready          = r_in_ready;
  assign out_valid         = (r_count != 2'd0);
  assign bck_step_cnt      = r_cnt;
  assign out_status        = w_head.status;
  assign out_read_num      = w_head.read_num;
  assign out_rd_addr       = w_head.rd_addr;
  assign out_wr_addr       = w_head.wr_addr;
  assign out_mem_wr_addr   = w_head.mem_wr_addr;
  assign out_fwd_size      = w_head.fwd_size;
  assign out_new_size      = w_head.new_size;
  assign out_new_last_size = w_head.new_last_size;
  assign out_bwd_i         = w_head.bwd_i;
  assign out_bwd_j         = w_head.bwd_j;
  assign out_output_c      = w_head.output_c;
  assign out_min_intv      = w_head.min_intv;
  assign out_iter_bound    = w_head.iter_bound;
  assign out_primary       = w_head.primary;
  assign out_pend          = w_head.pend;
  assign out_tok           = w_head.tok;
  assign out_finish        = w_head.finish;
  assign out_last_one      = w_head.last_one;

endmodule

// File: tb/tb_smem_bwd_ctrl_stage.sv
// tb/tb_smem_bwd_ctrl_stage.sv - self-checking bench for smem_bwd_ctrl_stage
module tb_smem_bwd_ctrl_stage;
  localparam int IDX_W = 7;
  localparam int RN_W  = 6;
  localparam int PEND_W = 256;
  localparam int TOK_W  = 96;
  localparam int MODV   = 1 << IDX_W;

  typedef struct packed {
    logic [5:0]        status;
    logic [RN_W-1:0]   read_num;
    logic [IDX_W-1:0]  rd_addr;
    logic [IDX_W-1:0]  wr_addr;
    logic [IDX_W-1:0]  mem_wr_addr;
    logic [IDX_W-1:0]  fwd_size;
    logic [IDX_W-1:0]  new_size;
    logic [IDX_W-1:0]  new_last_size;
    logic [IDX_W-1:0]  bwd_i;
    logic [IDX_W-1:0]  bwd_j;
    logic [7:0]        output_c;
    logic [IDX_W-1:0]  min_intv;
    logic              iter_bound;
    logic [63:0]       primary;
    logic [PEND_W-1:0] pend;
    logic [TOK_W-1:0]  tok;
  } in_t;

  typedef struct packed {
    in_t  b;
    logic finish;
    logic last_one;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  in_t  stim;
  out_t obs;
  logic [5:0] out_status;
  logic [RN_W-1:0] out_read_num;
  logic [IDX_W-1:0] out_rd_addr, out_wr_addr, out_mem_wr_addr, out_fwd_size, out_new_size;
  logic [IDX_W-1:0] out_new_last_size, out_bwd_i, out_bwd_j, out_min_intv;
  logic [7:0] out_output_c;
  logic out_iter_bound, out_finish, out_last_one;
  logic [63:0] out_primary;
  logic [PEND_W-1:0] out_pend;
  logic [TOK_W-1:0] out_tok;
  logic [15:0] bck_step_cnt;

  logic s_in_ready, s_out_valid, s_iter_bound, s_finish, s_last_one;
  logic [5:0] s_status;
  logic [RN_W-1:0] s_read_num;
  logic [IDX_W-1:0] s_rd_addr, s_wr_addr, s_mem_wr_addr, s_fwd_size, s_new_size;
  logic [IDX_W-1:0] s_new_last_size, s_bwd_i, s_bwd_j, s_min_intv;
  logic [7:0] s_output_c;
  logic [63:0] s_primary;
  logic [PEND_W-1:0] s_pend;
  logic [TOK_W-1:0] s_tok;
  logic [1:0] s_cnt;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   rnd_ready = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  smem_bwd_ctrl_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_status(stim.status), .in_read_num(stim.read_num), .in_rd_addr(stim.rd_addr),
    .in_wr_addr(stim.wr_addr), .in_mem_wr_addr(stim.mem_wr_addr), .in_fwd_size(stim.fwd_size),
    .in_new_size(stim.new_size), .in_new_last_size(stim.new_last_size), .in_bwd_i(stim.bwd_i),
    .in_bwd_j(stim.bwd_j), .in_output_c(stim.output_c), .in_min_intv(stim.min_intv),
    .in_iter_bound(stim.iter_bound), .in_primary(stim.primary), .in_pend(stim.pend), .in_tok(stim.tok),
    .out_status(out_status), .out_read_num(out_read_num), .out_rd_addr(out_rd_addr),
    .out_wr_addr(out_wr_addr), .out_mem_wr_addr(out_mem_wr_addr), .out_fwd_size(out_fwd_size),
    .out_new_size(out_new_size), .out_new_last_size(out_new_last_size), .out_bwd_i(out_bwd_i),
    .out_bwd_j(out_bwd_j), .out_output_c(out_output_c), .out_min_intv(out_min_intv),
    .out_iter_bound(out_iter_bound), .out_primary(out_primary), .out_pend(out_pend), .out_tok(out_tok),
    .out_finish(out_finish), .out_last_one(out_last_one), .out_valid(out_valid),
    .out_ready(out_ready), .bck_step_cnt(bck_step_cnt)
  );

  smem_bwd_ctrl_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_status(stim.status), .in_read_num(stim.read_num), .in_rd_addr(stim.rd_addr),
    .in_wr_addr(stim.wr_addr), .in_mem_wr_addr(stim.mem_wr_addr), .in_fwd_size(stim.fwd_size),
    .in_new_size(stim.new_size), .in_new_last_size(stim.new_last_size), .in_bwd_i(stim.bwd_i),
    .in_bwd_j(stim.bwd_j), .in_output_c(stim.output_c), .in_min_intv(stim.min_intv),
    .in_iter_bound(stim.iter_bound), .in_primary(stim.primary), .in_pend(stim.pend), .in_tok(stim.tok),
    .out_status(s_status), .out_read_num(s_read_num), .out_rd_addr(s_rd_addr),
    .out_wr_addr(s_wr_addr), .out_mem_wr_addr(s_mem_wr_addr), .out_fwd_size(s_fwd_size),
    .out_new_size(s_new_size), .out_new_last_size(s_new_last_size), .out_bwd_i(s_bwd_i),
    .out_bwd_j(s_bwd_j), .out_output_c(s_output_c), .out_min_intv(s_min_intv),
    .out_iter_bound(s_iter_bound), .out_primary(s_primary), .out_pend(s_pend), .out_tok(s_tok),
    .out_finish(s_finish), .out_last_one(s_last_one), .out_valid(s_out_valid),
    .out_ready(out_ready), .bck_step_cnt(s_cnt)
  );

  assign obs = {out_status, out_read_num, out_rd_addr, out_wr_addr, out_mem_wr_addr,
                out_fwd_size, out_new_size, out_new_last_size, out_bwd_i, out_bwd_j,
                out_output_c, out_min_intv, out_iter_bound, out_primary, out_pend, out_tok,
                out_finish, out_last_one};

  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference rules written on plain integers.
  function automatic bit ref_ib(input in_t x);
    int nls = int'(x.new_last_size);
    bit jb = (nls == 0) || (int'(x.bwd_j) == nls - 1);
    return (x.status == 6'b010000) && jb && (x.bwd_i != 0);
  endfunction

  function automatic out_t ref_model(input in_t x);
    out_t r;
    int nls = int'(x.new_last_size);
    int j   = int'(x.bwd_j);
    int i   = int'(x.bwd_i);
    int ns  = int'(x.new_size);
    bit jb  = (nls == 0) || (j == nls - 1);
    r = '0;
    if (x.status == 6'b001000) begin
      r.b = x;
      r.b.output_c = 8'd0;
      r.b.pend = '0;
    end else if (x.status == 6'b010000) begin
      r.b = x;
      r.finish   = jb && (ns == 0);
      r.last_one = jb && (ns == 1);
      r.b.iter_bound = x.iter_bound || (jb && i == 0);
      r.b.bwd_i = IDX_W'(x.iter_bound ? 0 : ((jb && i > 0) ? i - 1 : i));
      r.b.bwd_j = IDX_W'(jb ? 0 : (j + 1) % MODV);
      r.b.wr_addr = IDX_W'(jb ? (int'(x.fwd_size) + MODV - 1) % MODV : int'(x.wr_addr));
      r.b.new_last_size = IDX_W'(jb ? ns : nls);
      r.b.new_size = IDX_W'(jb ? 0 : ns);
    end
    return r;
  endfunction

  function automatic in_t mk(input logic [5:0] st, input int j, input int nls, input int i,
                             input int ns, input int fwd, input bit ib);
    in_t x;
    x.status = st; x.read_num = 6'h15; x.rd_addr = 7'h03; x.wr_addr = 7'h22;
    x.mem_wr_addr = 7'h11; x.fwd_size = IDX_W'(fwd); x.new_size = IDX_W'(ns);
    x.new_last_size = IDX_W'(nls); x.bwd_i = IDX_W'(i); x.bwd_j = IDX_W'(j);
    x.output_c = 8'h41; x.min_intv = 7'h05; x.iter_bound = ib;
    x.primary = 64'hDEAD_BEEF_0123_4567; x.pend = {8{32'hA5A5_0F0F}}; x.tok = {3{32'h1234_5678}};
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    int  s = $urandom_range(0, 9);
    x = mk(6'b010000, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 127), 1'($urandom_range(0, 3) == 0));
    x.status = (s < 5) ? 6'b010000 : (s == 5) ? 6'b001000 : (s == 6) ? 6'b000010 :
               (s == 7) ? 6'b100000 : (s == 8) ? 6'b000000 : 6'($urandom);
    x.read_num = RN_W'($urandom); x.rd_addr = IDX_W'($urandom); x.wr_addr = IDX_W'($urandom);
    x.output_c = 8'($urandom); x.primary = {$urandom, $urandom};
    x.pend = {8{$urandom}}; x.tok = {$urandom, $urandom, $urandom};
    return x;
  endfunction

  task automatic step(output bit acc);
    bit pop;
    @(negedge clk);
    chk("in_ready", 512'(in_ready), 512'(exp_q.size() < 2));
    chk("out_valid", 512'(out_valid), 512'(exp_q.size() > 0));
    chk("cnt", 512'(bck_step_cnt), 512'(16'(exp_cnt)));
    chk("cnt_sat", 512'(s_cnt), 512'((exp_cnt > 3) ? 3 : exp_cnt));
    acc = in_valid && (exp_q.size() < 2);
    pop = out_ready && (exp_q.size() > 0);
    if (pop) begin
      chk("beat", 512'(obs), 512'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back(ref_model(stim));
      if (ref_ib(stim)) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input in_t x);
    bit acc = 0;
    int n = 0;
    stim = x;
    in_valid = 1'b1;
    while (!acc && n < 40) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 512'(0), 512'(1));
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step(acc);
  endtask

  initial begin
    in_t x;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stim = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_obs", 512'(obs), 512'(0));
    chk("rst_valid", 512'(out_valid), 512'(0));
    chk("rst_ready", 512'(in_ready), 512'(0));
    chk("rst_cnt", 512'(bck_step_cnt), 512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 512'(in_ready), 512'(1));

    send(mk(6'b010000, 4, 5, 3, 2, 10, 1'b0));
    chk("A_bwd_j", 512'(out_bwd_j), 512'(0));
    chk("A_bwd_i", 512'(out_bwd_i), 512'(2));
    chk("A_wr_addr", 512'(out_wr_addr), 512'(9));
    chk("A_nls", 512'(out_new_last_size), 512'(2));
    chk("A_ns", 512'(out_new_size), 512'(0));
    chk("A_fin_last", 512'({out_finish, out_last_one}), 512'(0));
    send(mk(6'b010000, 4, 5, 0, 1, 10, 1'b0));
    chk("B_iter", 512'(out_iter_bound), 512'(1));
    chk("B_last", 512'(out_last_one), 512'(1));
    chk("B_bwd_i", 512'(out_bwd_i), 512'(0));
    send(mk(6'b010000, 4, 5, 0, 0, 10, 1'b0));
    chk("C_finish", 512'(out_finish), 512'(1));
    send(mk(6'b010000, 0, 0, 5, 3, 10, 1'b0));
    chk("D_bwd_j", 512'(out_bwd_j), 512'(0));
    chk("D_bwd_i", 512'(out_bwd_i), 512'(4));
    x = mk(6'b001000, 2, 6, 3, 2, 10, 1'b1);
    send(x);
    chk("E_out_c", 512'(out_output_c), 512'(0));
    chk("E_pend", 512'(out_pend), 512'(0));
    chk("E_primary", 512'(out_primary), 512'(x.primary));
    chk("E_bwd_ij", 512'({out_bwd_i, out_bwd_j, out_iter_bound}), 512'({x.bwd_i, x.bwd_j, x.iter_bound}));
    chk("E_status", 512'(out_status), 512'(6'b001000));
    send(mk(6'b000010, 4, 5, 3, 2, 10, 1'b0));
    chk("F_bubble", 512'(obs), 512'(0));
    drain();

    rnd_ready = 1;
    repeat (30) send(rand_in());
    rnd_ready = 0;
    drain();

    out_ready = 1'b0;
    send(rand_in());
    send(rand_in());
    rst = 1'b1;
    #1;
    chk("mid_rst_obs", 512'(obs), 512'(0));
    chk("mid_rst_valid", 512'(out_valid), 512'(0));
    chk("mid_rst_ready", 512'(in_ready), 512'(0));
    chk("mid_rst_cnt", 512'({bck_step_cnt, s_cnt}), 512'(0));
    exp_q.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    repeat (5) send(mk(6'b010000, 4, 5, 3, 2, 10, 1'b0));
    drain();
    chk("sat_cnt", 512'(s_cnt), 512'(3));
    chk("full_cnt", 512'(bck_step_cnt), 512'(5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
